// File: rtl/cm3_matrix_output_arbiter.sv
// Round-robin owner selection for one bus-matrix output stage, burst-preserving.
// Define OUT_ARB_LOCK_EN to add lock_in and keep HMASTLOCK sequences atomic.
module cm3_matrix_output_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_PORTS-1:0]   req_in,
  input  logic [2*NUM_PORTS-1:0] trans_in,
  input  logic                   HREADYM,
`ifdef OUT_ARB_LOCK_EN
  input  logic [NUM_PORTS-1:0]   lock_in,
`endif
  output logic [IDX_W-1:0]       addr_in_port,
  output logic                   no_port,
  output logic [NUM_PORTS-1:0]   active_in,
  output logic [IDX_W-1:0]       data_in_port,
  output logic                   data_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] next_addr;
  logic [IDX_W-1:0] next_last;
  logic             next_no_port;
  logic             owner_req;
  logic [1:0]       owner_trans;
  logic             owner_lock;
  logic             hold;
  logic             found;
  int               cand;

  // Current owner's request, transfer type and lock.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    owner_req   = 1'b0;
    owner_trans = 2'b00;
    owner_lock  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (addr_in_port == IDX_W'(i)) begin
        owner_req   = req_in[i];
        owner_trans = trans_in[2*i +: 2];
`ifdef OUT_ARB_LOCK_EN
        owner_lock  = lock_in[i];
`endif
      end
    end
  end

  // BUSY (01) and SEQ (11) share bit 0, which marks a burst continuation.
  assign hold = !no_port && owner_req && (owner_trans[0] || owner_lock);

  // Next-state: keep the owner on hold, otherwise rotate from last_grant+1.
  always_comb begin
    next_addr    = addr_in_port;
    next_no_port = no_port;
    next_last    = last_grant;
    found        = 1'b0;
    cand         = 0;
    if (!hold) begin
      next_no_port = 1'b1;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        cand = (int'(last_grant) + k) % NUM_PORTS;
        if (!found && req_in[cand]) begin
          found        = 1'b1;
          next_addr    = IDX_W'(cand);
          next_last    = IDX_W'(cand);
          next_no_port = 1'b0;
        end
      end
    end
  end

  // State register; a low HREADYM freezes everything.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      last_grant   <= LAST_IDX;
      data_in_port <= '0;
      data_valid   <= 1'b0;
    end else if (HREADYM) begin
      addr_in_port <= next_addr;
      no_port      <= next_no_port;
      last_grant   <= next_last;
      data_in_port <= addr_in_port;
      data_valid   <= !no_port;
    end
  end

  // Output decode, purely from registers.
  always_comb begin
    active_in = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!no_port && addr_in_port == IDX_W'(i)) active_in[i] = 1'b1;
    end
  end

endmodule
